demux_1: RTL and testbench
==========================

// Module: demux_1
// PURPOSE
//  Registered 1-to-2 demultiplexer/router: the inverse of the 2:1 4-bit mux.
//  One valid/ready input stream carries data plus a select bit. Each word is
//  steered to output A (sel=0) or output B (sel=1).
//  Each output owns a one-entry holding register, so outputs are fully registered.
//  Used to split one datapath bus toward two consumers, e.g. register file write vs. ALU operand.
// PARAMETERS
//  WIDTH   4   data width of input and both outputs
//  CNT_W   8   width of per-channel transfer counters (CONFIGURATION feature)
// PORTS
//  clk       in   1        single clock; all state updates on rising edge
//  rst       in   1        synchronous, active-high reset
//  in_valid  in   1        input word present
//  in_ready  out  1        block accepts input word this cycle
//  in_sel    in   1        0 -> channel A, 1 -> channel B
//  in_data   in   WIDTH    input word
//  a_valid   out  1        channel A holds a word
//  a_ready   in   1        channel A consumer takes word
//  a_data    out  WIDTH    channel A word
//  b_valid   out  1        channel B holds a word
//  b_ready   in   1        channel B consumer takes word
//  b_data    out  WIDTH    channel B word
//  cnt_a     out  CNT_W    words delivered on A (0 when feature disabled)
//  cnt_b     out  CNT_W    words delivered on B (0 when feature disabled)
// BEHAVIOUR
//  - Reset (rst=1 at a rising edge): full_a=full_b=0, a_data=b_data=0, cnt_a=cnt_b=0.
//    in_ready=0 while rst is high; any in-flight word is dropped.
//  - Per channel, two states: EMPTY (valid=0), FULL (valid=1).
//    - EMPTY->FULL on a push.
//    - FULL->EMPTY on a pop without a push.
//    - FULL->FULL on push+pop in the same cycle; the register takes the new word.
//    - EMPTY with push+pop cannot occur, because pop requires valid.
//  - Push to channel X: in_valid & in_ready & (in_sel selects X).
//    Pop on X: X_valid & X_ready.
//  - in_ready = !rst & (selected channel EMPTY | selected channel ready).
//    This path from X_ready to in_ready is combinational and intended.
//    in_ready depends on in_sel.
//  - Latency is 1 cycle: a word accepted at edge N appears on X_data with X_valid=1 after edge N.
//    There is no combinational path from in_data to the outputs.
//  - X_data and X_valid hold stable while X_valid & !X_ready.
//    The unselected channel is never modified.
//  - A stalled channel blocks only inputs addressed to it.
//    Words for the other channel flow at 1 per cycle.
//  - Output registers are updated only on a push, so data is not cleared on a pop.
//  - in_valid=0 or in_ready=0: no state change except pops.
//  - Throughput is 1 word/cycle sustained when the target consumer holds ready=1.
// CONFIGURATION
//  DEMUX_CNT_EN defined:
//    - cnt_a/cnt_b increment by 1 on each pop of their channel.
//    - They wrap modulo 2^CNT_W (255 -> 0 for CNT_W=8).
//    - They clear on rst.
//  DEMUX_CNT_EN undefined:
//    - The counter logic is not generated.
//    - cnt_a/cnt_b are tied to 0; the ports remain.
// TESTING
//  1 Reset: drive rst=1 for 2 cycles with in_valid=1.
//    -> in_ready=0, a_valid=b_valid=0, a_data=b_data=0, cnt_a=cnt_b=0.
//  2 Routing: drive in_data=4'hA,sel=0, then 4'h5,sel=1, with both readys=1.
//    -> a_data=A one cycle later, b_data=5 the cycle after, each valid for exactly 1 cycle.
//  3 Stall: a_ready=0; push 4'h3 (sel=0), then offer 4'h7 (sel=0) and hold it.
//    -> a_data stays 3, in_ready=0.
//    -> Meanwhile offer 4'h9 (sel=1): accepted, b_data=9.
//  4 Same-cycle pop+push: A is FULL with 4'h1, a_ready=1, push 4'h2 (sel=0).
//    -> in_ready=1, a_valid stays 1, a_data=2 next cycle.
//  5 Reset mid-operation: both channels FULL and stalled; assert rst for 1 cycle.
//    -> both valids=0, data=0, counters=0 next cycle; normal flow resumes after.
//  6 (DEMUX_CNT_EN, CNT_W=8): deliver 257 words on A.
//    -> cnt_a=1 (wrapped), cnt_b=0.
//    -> Rebuild without the macro: cnt_a=cnt_b=0 throughout.

Source files
------------

// File: rtl/demux_1_if.sv
// rtl/demux_1_if.sv - stream and status bundle for the 1-to-2 registered demultiplexer
interface demux_1_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport master (
        output in_valid, in_sel, in_data, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data, cnt_a, cnt_b
    );

    modport slave (
        input  in_valid, in_sel, in_data, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data, cnt_a, cnt_b
    );
endinterface

// File: rtl/demux_1.sv
// rtl/demux_1.sv - registered 1-to-2 router with one-entry holding register per channel
// Optional per-channel delivery counters are built when DEMUX_CNT_EN is defined.
module demux_1 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    demux_1_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

    chan_state_t      state_a_q, state_a_d;
    chan_state_t      state_b_q, state_b_d;
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             in_ready;
    logic             push_a, push_b;
    logic             pop_a, pop_b;

    // in_ready looks at the selected consumer's ready so a full channel can drain and refill in one cycle.
    always_comb begin
        pop_a    = (state_a_q == FULL) & bus.a_ready;
        pop_b    = (state_b_q == FULL) & bus.b_ready;
        in_ready = !rst & (bus.in_sel ? ((state_b_q == EMPTY) | bus.b_ready)
                                      : ((state_a_q == EMPTY) | bus.a_ready));
        push_a   = bus.in_valid & in_ready & !bus.in_sel;
        push_b   = bus.in_valid & in_ready &  bus.in_sel;

        state_a_d = state_a_q;
        a_data_d  = a_data_q;
        case (state_a_q)
            EMPTY:   if (push_a) state_a_d = FULL;
            FULL:    if (pop_a && !push_a) state_a_d = EMPTY;
            default: state_a_d = EMPTY;
        endcase
        if (push_a) a_data_d = bus.in_data;

        state_b_d = state_b_q;
        b_data_d  = b_data_q;
        case (state_b_q)
            EMPTY:   if (push_b) state_b_d = FULL;
            FULL:    if (pop_b && !push_b) state_b_d = EMPTY;
            default: state_b_d = EMPTY;
        endcase
        if (push_b) b_data_d = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_a_q <= EMPTY;
            state_b_q <= EMPTY;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else begin
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.a_valid  = (state_a_q == FULL);
    assign bus.a_data   = a_data_q;
    assign bus.b_valid  = (state_b_q == FULL);
    assign bus.b_data   = b_data_q;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    // Counters wrap naturally at 2^CNT_W.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (pop_a) cnt_a_d = cnt_a_q + 1'b1;
        if (pop_b) cnt_b_d = cnt_b_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign bus.cnt_a = cnt_a_q;
    assign bus.cnt_b = cnt_b_q;
`else
    assign bus.cnt_a = {CNT_W{1'b0}};
    assign bus.cnt_b = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_demux_1.sv
// tb/tb_demux_1.sv - directed and random checks of demux_1 against a behavioural model
module tb_demux_1;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_1_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux_1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    bit         m_known = 1'b0;
    bit         m_full_a, m_full_b;
    logic [3:0] m_a, m_b;
    int         m_pops_a, m_pops_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int pops);
`ifdef DEMUX_CNT_EN
        return 32'(pops % (1 << CNT_W));
`else
        return 32'(pops * 0);
`endif
    endfunction

    // One clock: apply inputs, compare every output with the model mid-cycle, advance the model.
    task automatic cycle(input bit r, input bit v, input bit s, input logic [3:0] d,
                         input bit ar, input bit br);
        bit exp_rdy, pop_a, pop_b, push_a, push_b;
        rst = r;
        bus.in_valid = v;
        bus.in_sel = s;
        bus.in_data = d;
        bus.a_ready = ar;
        bus.b_ready = br;
        @(negedge clk);
        exp_rdy = !r && (s ? (!m_full_b || br) : (!m_full_a || ar));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (m_known) begin
            chk("a_valid", 32'(bus.a_valid), 32'(m_full_a));
            chk("a_data",  32'(bus.a_data),  32'(m_a));
            chk("b_valid", 32'(bus.b_valid), 32'(m_full_b));
            chk("b_data",  32'(bus.b_data),  32'(m_b));
            chk("cnt_a",   32'(bus.cnt_a),   cnt_exp(m_pops_a));
            chk("cnt_b",   32'(bus.cnt_b),   cnt_exp(m_pops_b));
        end
        if (r) begin
            m_known = 1'b1;
            m_full_a = 1'b0; m_full_b = 1'b0;
            m_a = '0; m_b = '0;
            m_pops_a = 0; m_pops_b = 0;
        end else begin
            pop_a  = m_full_a && ar;
            pop_b  = m_full_b && br;
            push_a = v && exp_rdy && !s;
            push_b = v && exp_rdy && s;
            if (pop_a) m_pops_a++;
            if (pop_b) m_pops_b++;
            if (push_a) begin m_full_a = 1'b1; m_a = d; end
            else if (pop_a) m_full_a = 1'b0;
            if (push_b) begin m_full_b = 1'b1; m_b = d; end
            else if (pop_b) m_full_b = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_data = '0;
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;

        // Reset held two cycles with a word offered
        cycle(1, 1, 0, 4'hE, 1, 1);
        cycle(1, 1, 1, 4'hD, 1, 1);
        chk("rst_a_valid", 32'(bus.a_valid), 32'd0);
        chk("rst_b_data",  32'(bus.b_data),  32'd0);
        chk("rst_cnt_a",   32'(bus.cnt_a),   32'd0);

        // Routing
        cycle(0, 1, 0, 4'hA, 1, 1);
        chk("route_a_data", 32'(bus.a_data), 32'hA);
        cycle(0, 1, 1, 4'h5, 1, 1);
        chk("route_b_data",  32'(bus.b_data),  32'h5);
        chk("route_a_valid", 32'(bus.a_valid), 32'd0);
        cycle(0, 0, 0, 4'h0, 1, 1);
        chk("route_b_once", 32'(bus.b_valid), 32'd0);

        // Stall on A, B still flows
        cycle(0, 1, 0, 4'h3, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'h7, 0, 1);
        chk("stall_a_data", 32'(bus.a_data), 32'h3);
        cycle(0, 1, 1, 4'h9, 0, 0);
        chk("stall_b_data", 32'(bus.b_data), 32'h9);
        chk("stall_a_hold", 32'(bus.a_data), 32'h3);

        // Same-cycle pop and push on A
        cycle(0, 0, 0, 4'h0, 1, 1);
        cycle(0, 1, 0, 4'h1, 1, 1);
        cycle(0, 1, 0, 4'h2, 1, 1);
        chk("pp_a_valid", 32'(bus.a_valid), 32'd1);
        chk("pp_a_data",  32'(bus.a_data),  32'h2);

        // Reset with both channels full and stalled
        cycle(0, 1, 1, 4'hC, 0, 0);
        cycle(0, 0, 0, 4'h0, 0, 0);
        cycle(1, 1, 0, 4'hF, 0, 0);
        chk("mid_a_valid", 32'(bus.a_valid), 32'd0);
        chk("mid_b_valid", 32'(bus.b_valid), 32'd0);
        chk("mid_b_data",  32'(bus.b_data),  32'd0);
        cycle(0, 1, 0, 4'h6, 1, 1);
        chk("mid_resume", 32'(bus.a_data), 32'h6);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));

        // 257 deliveries on A to exercise counter wrap
        cycle(1, 0, 0, 4'h0, 1, 1);
        for (int i = 0; i < 257; i++) cycle(0, 1, 0, 4'($urandom), 1, 1);
        cycle(0, 0, 0, 4'h0, 1, 1);
`ifdef DEMUX_CNT_EN
        chk("wrap_cnt_a", 32'(bus.cnt_a), 32'd1);
`else
        chk("wrap_cnt_a", 32'(bus.cnt_a), 32'd0);
`endif
        chk("wrap_cnt_b", 32'(bus.cnt_b), 32'd0);
        cycle(0, 0, 0, 4'h0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
